// File: rtl/consec_seq_monitor_if.sv
// consec_seq_monitor_if: sequence event inputs and match/fail/status outputs of the monitor.
interface consec_seq_monitor_if #(parameter int CNT_W = 8);
    logic             a;
    logic             b;
    logic             c;
    logic             match;
    logic             fail;
    logic             busy;
    logic [3:0]       run_len;
    logic [CNT_W-1:0] match_count;
    logic [CNT_W-1:0] fail_count;
    modport master (output a, b, c, input match, fail, busy, run_len, match_count, fail_count);
    modport slave  (input a, b, c, output match, fail, busy, run_len, match_count, fail_count);
endinterface

// File: rtl/consec_seq_monitor.sv
// consec_seq_monitor: detects a ##1 b[*MIN_REP:MAX_REP] ##1 c, one attempt at a time.
// Define CONSEC_MON_STICKY_FAIL_EN to hold fail high from its first assertion until reset.
module consec_seq_monitor #(
    parameter int MIN_REP = 2,
    parameter int MAX_REP = 4,
    parameter int CNT_W   = 8
) (
    input logic                  clock,
    input logic                  reset,
    consec_seq_monitor_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ARMED, REP} state_e;
    localparam logic [3:0] MIN_L = 4'(MIN_REP);
    localparam logic [3:0] MAX_L = 4'(MAX_REP);
    state_e           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic             match_q, match_d, fail_q, fail_d;
    logic [CNT_W-1:0] mcnt_q, fcnt_q;
    always_comb begin
        state_d = IDLE;
        run_d   = 4'd0;
        match_d = 1'b0;
        fail_d  = 1'b0;
        case (state_q)
            IDLE:  state_d = bus.a ? ARMED : IDLE;
            ARMED: begin
                state_d = bus.b ? REP : IDLE;
                run_d   = bus.b ? 4'd1 : 4'd0;
                fail_d  = !bus.b;
            end
            REP: begin
                // shortest match wins: c closes the attempt before b can extend it
                if (run_q >= MIN_L && bus.c) match_d = 1'b1;
                else if (bus.b && run_q < MAX_L) begin
                    state_d = REP;
                    run_d   = run_q + 4'd1;
                end
                else fail_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            run_q   <= 4'd0;
            match_q <= 1'b0;
            fail_q  <= 1'b0;
            mcnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            match_q <= match_d;
`ifdef CONSEC_MON_STICKY_FAIL_EN
            fail_q  <= fail_q | fail_d;
`else
            fail_q  <= fail_d;
`endif
            if (match_d && mcnt_q != '1) mcnt_q <= mcnt_q + CNT_W'(1);
            if (fail_d && fcnt_q != '1) fcnt_q <= fcnt_q + CNT_W'(1);
        end
    end
    assign bus.match       = match_q;
    assign bus.fail        = fail_q;
    assign bus.busy        = state_q != IDLE;
    assign bus.run_len     = run_q;
    assign bus.match_count = mcnt_q;
    assign bus.fail_count  = fcnt_q;
endmodule

// File: tb/tb_consec_seq_monitor.sv
// tb_consec_seq_monitor: table-driven and hand-sequenced checks of consec_seq_monitor (MIN_REP=2, MAX_REP=4).
module tb_consec_seq_monitor;
`ifdef CONSEC_MON_STICKY_FAIL_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    typedef struct {
        logic [2:0] abc;
        logic       m;
        logic       f;
        logic       bz;
        logic [3:0] rl;
    } vec_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    consec_seq_monitor_if #(.CNT_W(8)) bus ();
    consec_seq_monitor #(.MIN_REP(2), .MAX_REP(4), .CNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clock = ~clock;
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask
    task automatic drive(input logic [2:0] abc);
        {bus.a, bus.b, bus.c} = abc;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic chk_all(input string nm, input logic m, f, bz, input logic [3:0] rl, input int mc, fc);
        chk({nm, ".match"}, 32'(bus.match), 32'(m));
        chk({nm, ".fail"}, 32'(bus.fail), 32'(f));
        chk({nm, ".busy"}, 32'(bus.busy), 32'(bz));
        chk({nm, ".run_len"}, 32'(bus.run_len), 32'(rl));
        chk({nm, ".match_count"}, 32'(bus.match_count), mc);
        chk({nm, ".fail_count"}, 32'(bus.fail_count), fc);
    endtask
    vec_t tbl[25];
    initial begin
        int  mc = 0;
        int  fc = 0;
        bit  seen = 1'b0;
        tbl = '{
            '{3'b100, 1'b0, 1'b0, 1'b0, 4'd0}, '{3'b010, 1'b0, 1'b0, 1'b1, 4'd0},
            '{3'b010, 1'b0, 1'b0, 1'b1, 4'd1}, '{3'b010, 1'b0, 1'b0, 1'b1, 4'd2},
            '{3'b001, 1'b0, 1'b0, 1'b1, 4'd3}, '{3'b000, 1'b1, 1'b0, 1'b0, 4'd0},
            '{3'b100, 1'b0, 1'b0, 1'b0, 4'd0}, '{3'b010, 1'b0, 1'b0, 1'b1, 4'd0},
            '{3'b001, 1'b0, 1'b0, 1'b1, 4'd1}, '{3'b000, 1'b0, 1'b1, 1'b0, 4'd0},
            '{3'b100, 1'b0, 1'b0, 1'b0, 4'd0}, '{3'b010, 1'b0, 1'b0, 1'b1, 4'd0},
            '{3'b010, 1'b0, 1'b0, 1'b1, 4'd1}, '{3'b110, 1'b0, 1'b0, 1'b1, 4'd2},
            '{3'b010, 1'b0, 1'b0, 1'b1, 4'd3}, '{3'b010, 1'b0, 1'b0, 1'b1, 4'd4},
            '{3'b000, 1'b0, 1'b1, 1'b0, 4'd0}, '{3'b100, 1'b0, 1'b0, 1'b0, 4'd0},
            '{3'b011, 1'b0, 1'b0, 1'b1, 4'd0}, '{3'b011, 1'b0, 1'b0, 1'b1, 4'd1},
            '{3'b011, 1'b0, 1'b0, 1'b1, 4'd2}, '{3'b100, 1'b1, 1'b0, 1'b0, 4'd0},
            '{3'b100, 1'b0, 1'b0, 1'b1, 4'd0}, '{3'b000, 1'b0, 1'b1, 1'b0, 4'd0},
            '{3'b000, 1'b0, 1'b0, 1'b0, 4'd0}
        };
        drive(3'b000);
        cyc();
        cyc();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 4'd0, 0, 0);
        reset = 1'b0;
        // each row: expected outputs seen during a cycle, then that cycle's inputs
        for (int i = 0; i < 25; i++) begin
            mc += int'(tbl[i].m);
            fc += int'(tbl[i].f);
            chk_all($sformatf("vec%0d", i), tbl[i].m, tbl[i].f | (STICKY & seen), tbl[i].bz, tbl[i].rl, mc, fc);
            seen |= tbl[i].f;
            drive(tbl[i].abc);
            cyc();
        end
        drive(3'b100); cyc();
        drive(3'b010); cyc();
        drive(3'b010); cyc();
        chk("mid.run_len", 32'(bus.run_len), 2);
        reset = 1'b1;
        drive(3'b010); cyc();
        reset = 1'b0;
        chk_all("abort", 1'b0, 1'b0, 1'b0, 4'd0, 0, 0);
        drive(3'b100); cyc();
        chk_all("fresh.armed", 1'b0, 1'b0, 1'b1, 4'd0, 0, 0);
        drive(3'b010); cyc();
        drive(3'b010); cyc();
        drive(3'b001); cyc();
        drive(3'b000);
        chk_all("fresh.match", 1'b1, 1'b0, 1'b0, 4'd0, 1, 0);
        reset = 1'b1; cyc(); reset = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            drive(3'b100); cyc();
            drive(3'b010); cyc();
            drive(3'b010); cyc();
            drive(3'b001); cyc();
            chk($sformatf("sat%0d.match", k), 32'(bus.match), 1);
            chk($sformatf("sat%0d.match_count", k), 32'(bus.match_count), k > 255 ? 255 : k);
        end
        drive(3'b100); cyc();
        drive(3'b000); cyc();
        chk("late.fail", 32'(bus.fail), 1);
        chk("late.fail_count", 32'(bus.fail_count), 1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("hold%0d.fail", k), 32'(bus.fail), 32'(STICKY));
        end
        chk("hold.match_count", 32'(bus.match_count), 255);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk_all("final", 1'b0, 1'b0, 1'b0, 4'd0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/consec_seq_monitor.md
CONSEC_SEQ_MONITOR -- requirements
Module: consec_seq_monitor

Interface
REQ-001 The block SHALL have parameter MIN_REP, default 2, minimum consecutive b cycles for a match (1..15).
REQ-002 The block SHALL have parameter MAX_REP, default 4, maximum consecutive b cycles for a match (MIN_REP..15).
REQ-003 The block SHALL have parameter CNT_W, default 8, width of the match and fail counters.
REQ-004 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, synchronous and active-high.
REQ-006 The block SHALL have ports a, b and c, each input, 1 bit, the sampled sequence events from the upstream demo stimulus.
REQ-007 The block SHALL have port match, output, 1 bit, registered one-cycle pulse on a complete sequence a ##1 b[*MIN_REP:MAX_REP] ##1 c.
REQ-008 The block SHALL have port fail, output, 1 bit, registered one-cycle pulse on an abandoned attempt.
REQ-009 The block SHALL have port busy, output, 1 bit, high while an attempt is in progress (state != IDLE).
REQ-010 The block SHALL have port run_len, output, 4 bits, current consecutive-b count of the active attempt.
REQ-011 The block SHALL have ports match_count and fail_count, each output, CNT_W bits, saturating event totals.

Function
REQ-012 The block SHALL implement FSM states IDLE, ARMED and REP, one attempt at a time with no overlapping attempts.
REQ-013 In IDLE, the block SHALL go to ARMED when a=1, otherwise stay in IDLE; b and c are ignored in IDLE.
REQ-014 In ARMED, the block SHALL go to REP with run_len=1 when b=1, otherwise pulse fail and return to IDLE.
REQ-015 In REP with run_len>=MIN_REP and c=1, the block SHALL pulse match and return to IDLE, regardless of b (shortest match wins).
REQ-016 Otherwise in REP with b=1 and run_len<MAX_REP, the block SHALL increment run_len and stay in REP.
REQ-017 Otherwise in REP with b=1 and run_len==MAX_REP, the block SHALL pulse fail (overrun) and return to IDLE.
REQ-018 Otherwise in REP with b=0, the block SHALL pulse fail (short run or missing c) and return to IDLE.
REQ-019 An a=1 while in ARMED or REP SHALL be ignored; a new attempt needs IDLE with a=1, earliest one cycle after match/fail.
REQ-020 The match and fail outputs SHALL be asserted in the cycle after the deciding input sample (latency 1) and never together.
REQ-021 run_len SHALL read 0 in IDLE and ARMED.
REQ-022 match_count and fail_count SHALL increment by 1 with each respective pulse and hold at 2^CNT_W-1 (no wrap).

Reset
REQ-023 With reset=1 at a clock edge, the block SHALL enter IDLE with match=0, fail=0, busy=0, run_len=0, match_count=0, fail_count=0.
REQ-024 A reset asserted mid-attempt SHALL abort the attempt silently, with no fail pulse and no count change; reset has priority over all inputs.

Configuration
REQ-025 When macro CONSEC_MON_STICKY_FAIL_EN is defined, the block SHALL hold fail high from its first assertion until reset, while FSM and counters keep running.
REQ-026 When CONSEC_MON_STICKY_FAIL_EN is undefined, fail SHALL be a one-cycle pulse per REQ-008.

Verification
REQ-027 The bench SHALL cover, with MIN_REP=2 and MAX_REP=4: a=1 @t0; b=1 @t1..t3; c=1 @t4 -> match=1 @t5 only; match_count=1; busy low @t5.
REQ-028 The bench SHALL cover: a @t0; b @t1 only; c @t2 -> fail @t3; fail_count=1; match_count=0.
REQ-029 The bench SHALL cover: a @t0; b @t1..t5 -> fail @t6 (overrun at run_len=4); run_len reads 4 @t5.
REQ-030 The bench SHALL cover: a @t0; b,c both 1 @t1..t3 -> match @t4 (c wins at run_len=2).
REQ-031 The bench SHALL cover: reset pulsed @t3 during REP -> no fail pulse; all outputs 0 @t4; a @t4 starts a fresh attempt.
REQ-032 The bench SHALL cover: 300 back-to-back matching attempts with CNT_W=8 -> match_count saturates at 255; with CONSEC_MON_STICKY_FAIL_EN defined, one failed attempt -> fail stays 1 until reset.
